// File: rtl/period_meter.sv
// Measures the period and high time of a slow asynchronous signal in clk cycles.
// One measurement per start request, abandoned after TIMEOUT_CYC cycles.
`timescale 1ns/1ps

module period_meter #(
  parameter int unsigned      CNT_W       = 26,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = 26'd50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIMIT = TIMEOUT_CYC - ONE;

  state_t           state, state_d;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] pcnt, pcnt_d;
  logic [CNT_W-1:0] hcnt, hcnt_d;
  logic [CNT_W-1:0] tcnt, tcnt_d;
  logic [CNT_W-1:0] period_d, high_time_d;
  logic             valid_d, timeout_d;
  logic             at_limit;

  assign rise     = s2 & ~s3;
  assign busy     = (state != IDLE);
  assign at_limit = (tcnt == LIMIT);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state;
    pcnt_d      = pcnt;
    hcnt_d      = hcnt;
    tcnt_d      = tcnt;
    period_d    = period;
    high_time_d = high_time;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;

    unique case (state)
      IDLE: begin
        // A start coinciding with the result pulse is dropped, not queued.
        if (start && !valid && !timeout) begin
          state_d = ARM;
          tcnt_d  = '0;
        end
      end
      ARM: begin
        tcnt_d = tcnt + ONE;
        if (at_limit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (rise) begin
          state_d = MEAS;
          pcnt_d  = ONE;
          hcnt_d  = ONE;
        end
      end
      MEAS: begin
        tcnt_d = tcnt + ONE;
        // Completion takes priority over the limit in the same cycle.
        if (rise) begin
          state_d     = IDLE;
          period_d    = pcnt;
          high_time_d = hcnt;
          valid_d     = 1'b1;
        end else if (at_limit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          pcnt_d = pcnt + ONE;
          hcnt_d = hcnt + CNT_W'(s2);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      pcnt      <= '0;
      hcnt      <= '0;
      tcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      s1        <= sig_in;
      s2        <= s1;
      s3        <= s2;
      pcnt      <= pcnt_d;
      hcnt      <= hcnt_d;
      tcnt      <= tcnt_d;
      period    <= period_d;
      high_time <= high_time_d;
      valid     <= valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule
